// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Imported by the loader top and its readback packer.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH
    } state_e;

    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Readback words produced by one full load: ceil(chain_len / data_w)
    function automatic int rb_words(input int chain_len, input int data_w);
        return (chain_len + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Config stream, readback stream and serial chain pins of the loader.
// master = loader side, slave = bitstream source / sink / chain side.
interface ccff_loader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] rb_data;
    logic              rb_valid;
    logic              rb_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;

    modport master (
        input  cfg_data, cfg_valid, rb_ready, ccff_tail,
        output cfg_ready, rb_data, rb_valid, ccff_head, ccff_shift_en
    );

    modport slave (
        output cfg_data, cfg_valid, rb_ready, ccff_tail,
        input  cfg_ready, rb_data, rb_valid, ccff_head, ccff_shift_en
    );
endinterface

// File: rtl/ccff_rb_pack.sv
// Readback deserializer: packs ccff_tail bits LSB-first into words and
// holds each word on a valid/ready register; flushes a zero-padded partial.
module ccff_rb_pack
    import ccff_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              kill_i,
    input  logic              shift_i,
    input  logic              last_i,
    input  logic              tail_i,
    input  logic              rb_ready_i,
    output logic [DATA_W-1:0] rb_data_o,
    output logic              rb_valid_o
);
    localparam int IW = idx_w(DATA_W);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IW-1:0]     pos_q, pos_d;
    logic              valid_q, valid_d;

    always_comb begin
        acc_d   = acc_q;
        pos_d   = pos_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && rb_ready_i) valid_d = 1'b0;
        if (shift_i) begin
            acc_d[pos_q] = tail_i;
            // accumulator is zeroed per word, so a partial is already padded
            if (last_i || pos_q == IW'(DATA_W - 1)) begin
                data_d  = acc_d;
                valid_d = 1'b1;
                acc_d   = '0;
                pos_d   = '0;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
        if (clr_i || kill_i) begin
            acc_d = '0;
            pos_d = '0;
        end
        if (kill_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            pos_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rb_data_o  = data_q;
    assign rb_valid_o = valid_q;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: serializes cfg words LSB-first onto ccff_head
// with one shift enable per bit, returning ccff_tail bits as readback words.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic prog_clk,
    input  logic pReset_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    ccff_loader_if.master bus
);
    localparam int IW = idx_w(DATA_W);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              full_q, full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic shift, last, buf_end, accept;
    logic clr, kill, rb_valid;

    assign shift   = (state_q == LOAD) && full_q
                     && !(rb_valid && !bus.rb_ready);
    assign last    = shift && (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign buf_end = shift && (idx_q == IW'(DATA_W - 1));
    assign accept  = bus.cfg_ready && bus.cfg_valid;
    assign clr     = (state_q == IDLE) && start && !abort;
    assign kill    = (state_q != IDLE) && abort;

    assign bus.cfg_ready     = (state_q == LOAD)
                               && (!full_q || buf_end || last);
    assign bus.ccff_shift_en = shift;
    assign bus.ccff_head     = shift && sh_q[idx_q];
    assign bus.rb_valid      = rb_valid;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = LOAD;
                    sh_d    = '0;
                    idx_d   = '0;
                    full_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (shift) begin
                    cnt_d = cnt_q + 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (buf_end) full_d = 1'b0;
                end
                // a word accepted on the last buffered bit follows with no bubble
                if (accept) begin
                    sh_d   = bus.cfg_data;
                    idx_d  = '0;
                    full_d = 1'b1;
                end
                if (last) begin
                    state_d = FLUSH;
                    full_d  = 1'b0;
                end
            end
            FLUSH: begin
                if (!rb_valid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            full_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            full_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    ccff_rb_pack #(
        .DATA_W (DATA_W)
    ) u_rb (
        .clk_i      (prog_clk),
        .rst_ni     (pReset_n),
        .clr_i      (clr),
        .kill_i     (kill),
        .shift_i    (shift),
        .last_i     (last),
        .tail_i     (bus.ccff_tail),
        .rb_ready_i (bus.rb_ready),
        .rb_data_o  (bus.rb_data),
        .rb_valid_o (rb_valid)
    );

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with a 12-flop chain model on ccff_shift_en.
// DATA_W=8, CHAIN_LEN=12.
module tb_ccff_loader;
    import ccff_pkg::*;

    localparam int DW = 8;
    localparam int CL = 12;
    localparam int RB_WORDS = rb_words(CL, DW);

    logic prog_clk = 1'b0;
    logic pReset_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;

    ccff_loader_if #(.DATA_W(DW)) bif ();

    ccff_loader #(
        .DATA_W    (DW),
        .CHAIN_LEN (CL),
        .CNT_W     (16)
    ) dut (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .bus      (bif)
    );

    always #5 prog_clk = ~prog_clk;

    // chain model: head enters at the top, tail leaves from bit 0
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] preset_val = '0;
    logic preset_req = 1'b0;
    logic sh_pend = 1'b0;
    logic hd_pend = 1'b0;

    assign bif.ccff_tail = chain[0];

    always @(negedge prog_clk) begin
        sh_pend <= bif.ccff_shift_en;
        hd_pend <= bif.ccff_head;
    end

    always @(posedge prog_clk) begin
        if (preset_req) chain <= preset_val;
        else if (sh_pend) chain <= {hd_pend, chain[CL-1:1]};
    end

    logic          heads [0:1023];
    logic [DW-1:0] rbw   [0:255];
    int nsh = 0, nrb = 0, ndone = 0, rb_at_done = 0;

    always @(negedge prog_clk) begin
        if (bif.ccff_shift_en) begin
            heads[nsh] <= bif.ccff_head;
            nsh <= nsh + 1;
        end
        if (bif.rb_valid && bif.rb_ready) begin
            rbw[nrb] <= bif.rb_data;
            nrb <= nrb + 1;
        end
        if (done) begin
            ndone <= ndone + 1;
            rb_at_done <= nrb;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, done, bif.cfg_ready, bif.rb_valid, bif.rb_data,
                    bif.ccff_head, bif.ccff_shift_en});
    endfunction

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic preset(input logic [CL-1:0] v);
        preset_val = v;
        preset_req = 1'b1;
        tick();
        preset_req = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] w);
        bit ok;
        ok = 1'b0;
        bif.cfg_data = w;
        bif.cfg_valid = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge prog_clk);
            if (bif.cfg_ready) ok = 1'b1;
            @(posedge prog_clk);
            #1;
        end
        bif.cfg_valid = 1'b0;
        chk("feed_accept", 32'(ok), 1);
    endtask

    task automatic wait_shifts(input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (nsh >= target) ok = 1'b1;
            else tick();
        end
        chk("shift_wait", 32'(ok), 1);
    endtask

    task automatic run_load(input int sc, input logic [DW-1:0] w0,
                            input logic [DW-1:0] w1, input int gap,
                            input bit bp, input bit mst, input bit crb,
                            input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [CL-1:0] ehead);
        int sb, rb0, db, gs, stall, dbad;
        bit ok;
        logic [CL-1:0] hv;
        sb = nsh;
        rb0 = nrb;
        db = ndone;
        bif.rb_ready = !bp;
        start = 1'b1;
        tick();
        start = 1'b0;
        fork
            begin
                feed(w0);
                if (mst) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                if (gap > 0) begin
                    wait_shifts(sb + DW);
                    gs = nsh;
                    repeat (gap) tick();
                    chk($sformatf("s%0d_gap_shifts", sc), nsh - gs, 0);
                end
                feed(w1);
            end
            begin
                if (bp) begin
                    ok = 1'b0;
                    for (int k = 0; k < 300 && !ok; k++) begin
                        @(negedge prog_clk);
                        if (bif.rb_valid) ok = 1'b1;
                    end
                    chk($sformatf("s%0d_rb_first", sc), 32'(ok), 1);
                    stall = 0;
                    dbad = 0;
                    for (int i = 0; i < 10; i++) begin
                        if (bif.ccff_shift_en) stall++;
                        if (!bif.rb_valid || bif.rb_data != 8'hFF) dbad++;
                        @(negedge prog_clk);
                    end
                    chk($sformatf("s%0d_bp_shifts", sc), stall, 0);
                    chk($sformatf("s%0d_bp_hold", sc), dbad, 0);
                    tick();
                    bif.rb_ready = 1'b1;
                end
            end
        join
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            tick();
            if (ndone > db) ok = 1'b1;
        end
        chk($sformatf("s%0d_done_seen", sc), 32'(ok), 1);
        repeat (3) tick();
        chk($sformatf("s%0d_done_once", sc), ndone - db, 1);
        chk($sformatf("s%0d_busy_end", sc), 32'(busy), 0);
        chk($sformatf("s%0d_shifts", sc), nsh - sb, CL);
        hv = '0;
        for (int i = 0; i < CL; i++) hv[i] = heads[sb + i];
        chk($sformatf("s%0d_heads", sc), 32'(hv), 32'(ehead));
        chk($sformatf("s%0d_chain", sc), 32'(chain), 32'(ehead));
        if (crb) begin
            chk($sformatf("s%0d_rb_count", sc), nrb - rb0, RB_WORDS);
            chk($sformatf("s%0d_rb0", sc), 32'(rbw[rb0]), 32'(e0));
            chk($sformatf("s%0d_rb1", sc), 32'(rbw[rb0 + 1]), 32'(e1));
        end
        if (bp) chk($sformatf("s%0d_rb_before_done", sc), rb_at_done - rb0, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sb, db, stray;
        bif.cfg_data = '0;
        bif.cfg_valid = 1'b0;
        bif.rb_ready = 1'b1;

        // 1: reset
        #2 pReset_n = 1'b0;
        #1 chk("rst_outs", outs(), 0);
        repeat (2) @(posedge prog_clk);
        #1 pReset_n = 1'b1;
        tick();
        chk("idle_ready", 32'(bif.cfg_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(8'hA5);
        tick();
        tick();
        chk("pre_rst_active", 32'({busy, bif.ccff_shift_en}), 32'h3);
        #2 pReset_n = 1'b0;
        #1 chk("rst_async", outs(), 0);
        @(posedge prog_clk);
        #1 pReset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bif.cfg_ready || busy) stray++;
        end
        chk("rst_release_idle", stray, 0);

        // 2: basic load, then 6: immediate repeat with an ignored start
        preset(12'hFFF);
        run_load(2, 8'hA5, 8'h03, 0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h0F, 12'h3A5);
        run_load(6, 8'hA5, 8'h03, 0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h03, 12'h3A5);

        // 3: input gap between words
        preset(12'hFFF);
        run_load(3, 8'hA5, 8'h03, 5, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h0F, 12'h3A5);

        // 4: readback backpressure
        preset(12'hFFF);
        run_load(4, 8'hA5, 8'h03, 0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h0F, 12'h3A5);

        // 5: abort after 5 shifts, then a clean reload
        preset(12'hFFF);
        sb = nsh;
        db = ndone;
        bif.rb_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(8'hA5);
        wait_shifts(sb + 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s5_busy", 32'(busy), 0);
        chk("s5_rb_valid", 32'(bif.rb_valid), 0);
        repeat (20) tick();
        chk("s5_no_done", ndone - db, 0);
        chk("s5_ready", 32'(bif.cfg_ready), 0);
        run_load(5, 8'hA5, 8'h03, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 12'h3A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
